// File: rtl/w_ctrl_level.sv
// Write-side controller of the async FIFO: write pointers, r_ptr synchroniser, level/full/afull/overflow status.
// Status updates one edge after a write; read-pointer moves reach the flags after SYNC_STAGES+1 edges; writes are ignored while full.
module w_ctrl_level #(
  parameter int ADDRESS_SIZE = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic                    w_en,
  input  logic                    w_ovf_clr,
  input  logic [ADDRESS_SIZE:0]   r_ptr,
  output logic [ADDRESS_SIZE:0]   w_ptr,
  output logic [ADDRESS_SIZE-1:0] w_addr,
  output logic                    w_full,
  output logic                    w_afull,
  output logic [ADDRESS_SIZE:0]   w_level,
  output logic                    w_overflow
);

  localparam logic [ADDRESS_SIZE:0] DEPTH_V = {1'b1, {ADDRESS_SIZE{1'b0}}};
  localparam logic [ADDRESS_SIZE:0] AFULL_V = (ADDRESS_SIZE+1)'(AFULL_THRESH);

  logic [ADDRESS_SIZE:0] r_bin;
  logic [ADDRESS_SIZE:0] r_gray;
  logic                  r_full;
  logic                  r_afull;
  logic [ADDRESS_SIZE:0] r_level;
  logic                  r_ovf;

  // r_ptr is asynchronous to w_clk; only the first stage may go metastable.
  (* ASYNC_REG = "TRUE" *) logic [ADDRESS_SIZE:0] r_sync0;
  logic [ADDRESS_SIZE:0] r_sync [SYNC_STAGES-1];

  logic                  w_wr_ok;
  logic [ADDRESS_SIZE:0] w_bnext;
  logic [ADDRESS_SIZE:0] w_gnext;
  logic [ADDRESS_SIZE:0] w_rq_gray;
  logic [ADDRESS_SIZE:0] w_rq_bin;
  logic [ADDRESS_SIZE:0] w_lvl_next;

  assign w_wr_ok    = w_en & ~r_full;
  assign w_bnext    = r_bin + {{ADDRESS_SIZE{1'b0}}, w_wr_ok};
  assign w_gnext    = w_bnext ^ (w_bnext >> 1);
  assign w_rq_gray  = r_sync[SYNC_STAGES-2];
  // Modular difference stays correct across pointer wraps.
  assign w_lvl_next = w_bnext - w_rq_bin;

  always_comb begin
    w_rq_bin = '0;
    for (int i = 0; i <= ADDRESS_SIZE; i++) begin
      w_rq_bin[i] = ^(w_rq_gray >> i);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_sync0 <= '0;
      for (int i = 0; i < SYNC_STAGES-1; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_bin     <= w_bnext;
      r_gray    <= w_gnext;
      r_level   <= w_lvl_next;
      r_full    <= (w_lvl_next == DEPTH_V);
      r_afull   <= (w_lvl_next >= AFULL_V);
      // A write attempt while full beats a same-cycle clear.
      r_ovf     <= (w_en & r_full) | (r_ovf & ~w_ovf_clr);
      r_sync0   <= r_ptr;
      r_sync[0] <= r_sync0;
      for (int i = 1; i < SYNC_STAGES-1; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_ptr      = r_gray;
  assign w_addr     = r_bin[ADDRESS_SIZE-1:0];
  assign w_full     = r_full;
  assign w_afull    = r_afull;
  assign w_level    = r_level;
  assign w_overflow = r_ovf;

endmodule

// File: tb/tb_w_ctrl_level.sv
// Bench for w_ctrl_level (ADDRESS_SIZE=2, SYNC_STAGES=2, AFULL_THRESH=3): count-based model feeds a scoreboard queue.
module tb_w_ctrl_level;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_en = 1'b0;
  logic       w_ovf_clr = 1'b0;
  logic [2:0] r_ptr = 3'b000;
  logic [2:0] w_ptr;
  logic [1:0] w_addr;
  logic       w_full;
  logic       w_afull;
  logic [2:0] w_level;
  logic       w_overflow;

  w_ctrl_level #(.ADDRESS_SIZE(2), .SYNC_STAGES(2), .AFULL_THRESH(3)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .w_ovf_clr(w_ovf_clr),
    .r_ptr(r_ptr), .w_ptr(w_ptr), .w_addr(w_addr), .w_full(w_full),
    .w_afull(w_afull), .w_level(w_level), .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] sb[$];
  logic [10:0] exp_v;

  // Model state: total accepted writes, read counts as seen by the write side.
  int   m_w = 0;
  int   m_lvl = 0;
  bit   m_full = 0;
  bit   m_ovf = 0;
  int   rh1 = 0;
  int   rh2 = 0;
  int   rc = 0;

  function automatic logic [2:0] gray3(input int v);
    logic [2:0] b;
    b = v[2:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [10:0] obs();
    return {w_ptr, w_addr, w_full, w_afull, w_level, w_overflow};
  endfunction

  // Apply one cycle of stimulus, push the model's post-edge outputs, advance past the edge.
  task automatic drive(input bit rst, input bit en, input bit clr, input int rcnt);
    logic [2:0] lv;
    w_rst = rst; w_en = en; w_ovf_clr = clr; r_ptr = gray3(rcnt);
    if (rst) begin
      m_w = 0; m_lvl = 0; m_full = 0; m_ovf = 0; rh1 = 0; rh2 = 0;
    end else begin
      m_ovf = (en && m_full) || (m_ovf && !clr);
      if (en && !m_full) m_w++;
      m_lvl = m_w - rh2;
      m_full = (m_lvl == 4);
      rh2 = rh1; rh1 = rcnt;
    end
    lv = m_lvl[2:0];
    sb.push_back({gray3(m_w), m_w[1:0], m_full, (m_lvl >= 3), lv, m_ovf});
    @(posedge w_clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 1'b0, 1'b0, 0);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL reset[%0d] got %b want %b", i, obs(), exp_v); end
    end
    n_vec++;
    if (w_ptr !== 3'b000) begin n_err++; $display("FAIL reset_ptr got %b want 000", w_ptr); end
  endtask

  task automatic test_fill();
    logic [2:0] ptr_tab [4];
    ptr_tab = '{3'b001, 3'b011, 3'b010, 3'b110};
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (w_addr !== 2'(i)) begin n_err++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, w_addr, i); end
      drive(1'b0, 1'b1, 1'b0, 0);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL fill[%0d] got %b want %b", i, obs(), exp_v); end
      n_vec++;
      if (w_ptr !== ptr_tab[i] || w_level !== 3'(i+1) || w_afull !== (i >= 2) || w_full !== (i == 3)) begin
        n_err++;
        $display("FAIL fill_tab[%0d] got ptr=%b lvl=%0d af=%b f=%b want ptr=%b lvl=%0d", i, w_ptr, w_level, w_afull, w_full, ptr_tab[i], i+1);
      end
    end
  endtask

  task automatic test_overflow();
    bit en_t [7];
    bit clr_t [7];
    bit ovf_t [7];
    en_t  = '{1, 1, 0, 0, 1, 0, 0};
    clr_t = '{0, 0, 0, 0, 1, 1, 0};
    ovf_t = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, en_t[i], clr_t[i], 0);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL ovf[%0d] got %b want %b", i, obs(), exp_v); end
      n_vec++;
      if (w_overflow !== ovf_t[i] || w_ptr !== 3'b110 || w_full !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_tab[%0d] got ovf=%b ptr=%b full=%b want ovf=%b ptr=110 full=1", i, w_overflow, w_ptr, w_full, ovf_t[i]);
      end
    end
  endtask

  task automatic test_read_latency();
    rc = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, rc);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL rdlat[%0d] got %b want %b", i, obs(), exp_v); end
      n_vec++;
      if (i < 2 && (w_full !== 1'b1 || w_level !== 3'd4)) begin
        n_err++; $display("FAIL rdlat_hold[%0d] got f=%b lvl=%0d want f=1 lvl=4", i, w_full, w_level);
      end else if (i == 2 && (w_full !== 1'b0 || w_level !== 3'd3 || w_afull !== 1'b1)) begin
        n_err++; $display("FAIL rdlat_edge3 got f=%b lvl=%0d af=%b want f=0 lvl=3 af=1", w_full, w_level, w_afull);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 0);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_rst got %b want %b", obs(), exp_v); end
    rc = 0;
    for (int k = 1; k <= 14; k++) begin
      drive(1'b0, k <= 10, 1'b0, rc);
      if (k <= 10) rc = k;
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL wrap[%0d] got %b want %b", k, obs(), exp_v); end
      n_vec++;
      if (w_level > 3'd4) begin n_err++; $display("FAIL wrap_lvl[%0d] got %0d want <=4", k, w_level); end
      if (k <= 10) begin
        n_vec++;
        if (w_ptr[2] !== ((k / 4) % 2 == 1)) begin
          n_err++; $display("FAIL wrap_msb[%0d] got %b want %0d", k, w_ptr[2], (k / 4) % 2);
        end
      end
    end
    n_vec++;
    if (w_level !== 3'd0) begin n_err++; $display("FAIL wrap_drain got %0d want 0", w_level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, rc);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL mid_fill[%0d] got %b want %b", i, obs(), exp_v); end
    end
    rc = rc + 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, rc);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL mid_read[%0d] got %b want %b", i, obs(), exp_v); end
    end
    n_vec++;
    if (w_level !== 3'd3 || w_overflow !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got lvl=%0d ovf=%b want lvl=3 ovf=1", w_level, w_overflow);
    end
    rc = 0;
    drive(1'b1, 1'b1, 1'b0, rc);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== 11'd0 || exp_v !== 11'd0) begin n_err++; $display("FAIL mid_rst got %b want 0", obs()); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, rc);
      exp_v = sb.pop_front(); n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL mid_post[%0d] got %b want %b", i, obs(), exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_latency();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/w_ctrl_level.md
Name: w_ctrl_level

Overview:
- Parametrised write-side controller for the async FIFO. Runs entirely in the write clock domain.
- Owns the binary and Gray write pointers and synchronises the Gray read pointer through a configurable number of flops.
- Produces registered full, almost-full, fill-level and sticky-overflow status.
- Drives the dual-port RAM write address; pairs with the read-side controller.

Parameters:
- ADDRESS_SIZE, 4, RAM address width; depth DEPTH = 2^ADDRESS_SIZE; legal range >= 1.
- SYNC_STAGES, 2, number of flops in the r_ptr synchroniser; legal range >= 2.
- AFULL_THRESH, 12, level at or above which w_afull asserts; legal range 1..DEPTH.

Ports:
- w_clk  input  1  write-domain clock; all state on rising edge.
- w_rst  input  1  synchronous active-high reset.
- w_en  input  1  write request.
- w_ovf_clr  input  1  clears w_overflow.
- r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from the read domain (asynchronous to w_clk).
- w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer, to the read domain.
- w_addr  output  ADDRESS_SIZE  RAM write address = w_bin[ADDRESS_SIZE-1:0].
- w_full  output  1  registered full flag.
- w_afull  output  1  registered almost-full flag.
- w_level  output  ADDRESS_SIZE+1  registered fill level as seen by the write side, 0..DEPTH.
- w_overflow  output  1  sticky flag; set by a write attempt while full.

Behaviour:
- Reset: the following clear to 0 on a w_clk edge with w_rst=1, regardless of any other input:
  - w_bin, w_ptr, w_full, w_afull, w_level, w_overflow;
  - every synchroniser stage.
- Reset mid-operation discards the pointer state; the read side must be reset in the same window.
- Write accept: wr_ok = w_en & !w_full.
  - w_bnext = w_bin + wr_ok, modulo 2^(ADDRESS_SIZE+1).
  - w_gnext = w_bnext ^ (w_bnext >> 1).
  - w_bin <= w_bnext; w_ptr <= w_gnext.
  - The RAM write strobe is wr_ok, owned by the top level; the write uses the current w_addr.
- Synchroniser: r_ptr passes through SYNC_STAGES flops to give rq_gray.
  - The first stage carries the ASYNC_REG attribute.
  - rq_bin = Gray-to-binary of rq_gray: bit i = XOR of rq_gray bits [ADDRESS_SIZE:i].
- Level: lvl_next = (w_bnext - rq_bin) mod 2^(ADDRESS_SIZE+1); w_level <= lvl_next.
- Flags, both registered from next-state values so they are valid in the cycle after the write:
  - w_full <= (lvl_next == DEPTH).
  - w_afull <= (lvl_next >= AFULL_THRESH).
- Latency:
  - Write at edge N: w_level/w_full/w_afull reflect it after edge N.
  - A read-pointer change reaches the flags after SYNC_STAGES+1 edges.
  - Flags are therefore pessimistic; they never under-report the level.
- Full boundary: with w_full=1, w_en is ignored and pointers hold. No wrap beyond DEPTH is possible.
- Overflow: w_overflow <= (w_overflow | (w_en & w_full)) & !w_ovf_clr.
  - Exception: set wins over clear in the same cycle, i.e. when w_en & w_full & w_ovf_clr all hold, the next value is 1.
- Wrap-around: the pointer MSB toggles every DEPTH writes; level arithmetic is modular, so it is correct across wraps.
- Gray output: w_ptr changes by at most one bit per cycle.

Test Plan (ADDRESS_SIZE=2, DEPTH=4, AFULL_THRESH=3, SYNC_STAGES=2):
- Reset then idle, r_ptr=0 -> all outputs 0; w_ptr=000.
- w_en=1 for 4 cycles, r_ptr=0:
  - w_addr 0,1,2,3;
  - w_ptr sequence 001,011,010,110;
  - w_level 1,2,3,4;
  - w_afull rises after the 3rd write; w_full after the 4th.
- Continue w_en=1 while full -> pointers hold at w_ptr=110; w_overflow=1 next cycle and stays after w_en drops.
- Pulse w_ovf_clr together with w_en while full -> w_overflow stays 1. Pulse w_ovf_clr alone -> w_overflow=0 next cycle.
- Full, then drive r_ptr=001 (one read):
  - w_full and w_level stay at 1/4 for 2 edges;
  - at the 3rd edge w_full=0, w_level=3, w_afull=1.
- Wrap test: 10 writes interleaved with matching r_ptr Gray updates -> w_bin MSB toggles after the 4th and 8th writes; w_level never exceeds 4 and returns to 0 when reads catch up.
- Assert w_rst while w_level=3 -> next edge all outputs 0, including w_overflow and the synchroniser contents.
